// File: rtl/pipe_scoreboard.sv
// Register scoreboard and issue/stall controller at ID: per-register latency countdowns,
// RAW/WAW/MUL-structural hazard detection, and a saturating stall counter.

module scb_cnt #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [CNT_WIDTH-1:0] set_val,
  output logic [CNT_WIDTH-1:0] cnt
);
  // A new issue overrides the countdown of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (set)         cnt <= set_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end
endmodule

module pipe_scoreboard #(
  parameter int REG_DIR_WIDTH = 3,
  parameter int CNT_WIDTH     = 3,
  parameter int ALU_LAT       = 1,
  parameter int LOAD_LAT      = 2,
  parameter int MUL_LAT       = 4,
  parameter int FWD_EN        = 1,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_DIR_WIDTH-1:0]     id_rs,
  input  logic [REG_DIR_WIDTH-1:0]     id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic [REG_DIR_WIDTH-1:0]     id_rd,
  input  logic                         id_reg_write,
  input  logic [1:0]                   id_unit,
  input  logic                         flush,
  output logic                         stall,
  output logic                         issue,
  output logic [2**REG_DIR_WIDTH-1:0]  busy_mask,
  output logic                         mul_busy,
  output logic [STALL_CNT_W-1:0]       stall_count
);
  localparam int NUM_REGS = 2**REG_DIR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ALU_L  = CNT_WIDTH'(ALU_LAT);
  localparam logic [CNT_WIDTH-1:0] LOAD_L = CNT_WIDTH'(LOAD_LAT);
  localparam logic [CNT_WIDTH-1:0] MUL_L  = CNT_WIDTH'(MUL_LAT);
  localparam logic [CNT_WIDTH-1:0] THR    = CNT_WIDTH'(FWD_EN != 0 ? 1 : 0);

  generate
    if (ALU_LAT < 1 || LOAD_LAT < 1 || MUL_LAT < 1) begin : g_lat_chk
      $error("pipe_scoreboard: latency parameters must be >= 1");
    end
    if ((2**CNT_WIDTH) - 1 < ALU_LAT || (2**CNT_WIDTH) - 1 < LOAD_LAT ||
        (2**CNT_WIDTH) - 1 < MUL_LAT) begin : g_cnt_chk
      $error("pipe_scoreboard: CNT_WIDTH too narrow for latencies");
    end
  endgenerate

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0]               mul_cnt;
  logic [CNT_WIDTH-1:0]               lat;
  logic raw_rs, raw_rt, waw, struct_hz, wr_en;

  always_comb begin
    case (id_unit)
      2'd1:    lat = LOAD_L;
      2'd2:    lat = MUL_L;
      default: lat = ALU_L;
    endcase
  end

  assign raw_rs    = id_use_rs & (id_rs != '0) & (cnt[id_rs] > THR);
  assign raw_rt    = id_use_rt & (id_rt != '0) & (cnt[id_rt] > THR);
  assign waw       = id_reg_write & (id_rd != '0) & (cnt[id_rd] > lat);
  assign struct_hz = (id_unit == 2'd2) & (mul_cnt != '0);
  assign stall     = id_valid & ~flush & (raw_rs | raw_rt | waw | struct_hz);
  assign issue     = id_valid & ~flush & ~stall;
  assign wr_en     = issue & id_reg_write & (id_rd != '0);

  // r0 is hardwired idle; every other register gets its own countdown.
  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;
  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      scb_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .set     (wr_en & (id_rd == REG_DIR_WIDTH'(r))),
        .set_val (lat),
        .cnt     (cnt[r])
      );
      assign busy_mask[r] = (cnt[r] != '0);
    end
  endgenerate

  scb_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_mul_cnt (
    .clk     (clk),
    .rst     (rst),
    .set     (issue & (id_unit == 2'd2)),
    .set_val (MUL_L),
    .cnt     (mul_cnt)
  );
  assign mul_busy = (mul_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_count <= '0;
    else if (stall && stall_count != '1)  stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a vector table on the default configuration plus
// hand sequences for reset, FWD_EN=0 forwarding and stall-counter saturation.

module tb_pipe_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_reg_write, flush;
  logic [2:0] id_rs, id_rt, id_rd;
  logic [1:0] id_unit;
  logic stall, issue, mul_busy;
  logic [7:0] busy_mask;
  logic [15:0] stall_count;
  logic a_stall, a_issue, a_mul_busy;
  logic [7:0] a_busy_mask;
  logic [3:0] a_stall_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_unit(id_unit), .flush(flush),
    .stall(stall), .issue(issue), .busy_mask(busy_mask), .mul_busy(mul_busy),
    .stall_count(stall_count)
  );

  pipe_scoreboard #(.FWD_EN(0), .STALL_CNT_W(4)) u_alt (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_unit(id_unit), .flush(flush),
    .stall(a_stall), .issue(a_issue), .busy_mask(a_busy_mask), .mul_busy(a_mul_busy),
    .stall_count(a_stall_count)
  );

  typedef struct {
    logic v; logic [2:0] rs; logic [2:0] rt; logic urs; logic urt;
    logic [2:0] rd; logic rw; logic [1:0] unit; logic fl;
    logic e_stall; logic e_issue; logic [7:0] e_busy; logic e_mul;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic urs, logic urt,
                              logic [2:0] rd, logic rw, logic [1:0] unit, logic fl,
                              logic es, logic ei, logic [7:0] eb, logic em);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.rd = rd; x.rw = rw;
    x.unit = unit; x.fl = fl; x.e_stall = es; x.e_issue = ei; x.e_busy = eb; x.e_mul = em;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd,
                       input logic rw, input logic [1:0] unit, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_unit = unit; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Fields: v rs rt urs urt rd rw unit fl | stall issue busy mul
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8'h00,0)); // idle
    tbl.push_back(mk(1,0,0,0,0,2,1,1,0, 0,1,8'h00,0)); // LW r2
    tbl.push_back(mk(1,2,1,1,1,4,1,0,0, 1,0,8'h04,0)); // ADD r4,r2,r1 load-use
    tbl.push_back(mk(1,2,1,1,1,4,1,0,0, 0,1,8'h04,0)); // issues via bypass
    tbl.push_back(mk(1,4,4,1,1,5,1,0,0, 0,1,8'h10,0)); // SUB r5,r4,r4 back-to-back
    tbl.push_back(mk(1,1,1,1,1,6,1,2,0, 0,1,8'h20,0)); // MUL r6
    tbl.push_back(mk(1,0,0,0,0,7,1,2,0, 1,0,8'h40,1)); // MUL r7 structural
    tbl.push_back(mk(1,0,0,0,0,7,1,2,0, 1,0,8'h40,1));
    tbl.push_back(mk(1,0,0,0,0,7,1,2,0, 1,0,8'h40,1));
    tbl.push_back(mk(1,0,0,0,0,7,1,2,0, 1,0,8'h40,1));
    tbl.push_back(mk(1,0,0,0,0,7,1,2,0, 0,1,8'h00,0)); // MUL idle again
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0, 1,0,8'h80,1)); // ADD r7 WAW, cnt7=4
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0, 1,0,8'h80,1)); // cnt7=3
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0, 1,0,8'h80,1)); // cnt7=2
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0, 0,1,8'h80,1)); // cnt7=1 -> issue
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8'h80,0)); // cnt7 reloaded to ALU_LAT
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8'h00,0));
    tbl.push_back(mk(1,0,0,0,0,3,1,1,0, 0,1,8'h00,0)); // LW r3
    tbl.push_back(mk(1,3,3,1,1,5,1,0,1, 0,0,8'h08,0)); // hazardous but flushed
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8'h08,0)); // r5 never recorded
    tbl.push_back(mk(1,0,0,0,0,0,1,2,0, 0,1,8'h00,0)); // write to r0 (MUL unit)
    tbl.push_back(mk(1,0,0,1,1,1,0,0,0, 0,1,8'h00,1)); // read r0, rd1 without write
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8'h00,1)); // nothing recorded for r1

    @(negedge clk);
    chk("reset_busy", busy_mask, 0);
    chk("reset_stall", stall, 0);
    chk("reset_issue", issue, 0);
    chk("reset_mul", mul_busy, 0);
    chk("reset_count", stall_count, 0);
    next();
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
            tbl[i].rd, tbl[i].rw, tbl[i].unit, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d_issue", i), issue, tbl[i].e_issue);
      chk($sformatf("v%0d_busy", i), busy_mask, tbl[i].e_busy);
      chk($sformatf("v%0d_mul", i), mul_busy, tbl[i].e_mul);
      next();
    end
    idle();
    // stalls: 1 load-use + 4 MUL structural + 3 WAW
    chk("table_stall_count", stall_count, 8);

    // Asynchronous reset mid-run with cnt[3]=2.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    next();
    idle();
    #1;
    chk("pre_rst_busy", busy_mask, 8'h08);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy_mask, 0);
    chk("async_rst_count", stall_count, 0);
    chk("async_rst_alt_count", a_stall_count, 0);
    next();
    rst = 1'b0;

    // ALU back-to-back: bypass on default, one stall with FWD_EN=0.
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    @(negedge clk);
    chk("alu_add_issue", issue, 1);
    chk("alu_add_alt_issue", a_issue, 1);
    next();
    drive(1, 3, 3, 1, 1, 5, 1, 0, 0);
    @(negedge clk);
    chk("fwd1_sub_stall", stall, 0);
    chk("fwd1_sub_issue", issue, 1);
    chk("fwd0_sub_stall", a_stall, 1);
    chk("fwd0_sub_issue", a_issue, 0);
    next();
    @(negedge clk);
    chk("fwd0_sub_issue2", a_issue, 1);
    next();
    idle();
    repeat (4) next();

    // Continuous MUL stream: one issue then four structural stalls, repeating.
    drive(1, 0, 0, 0, 0, 6, 1, 2, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("mulstream%0d_stall", i), stall, (i % 5) != 0);
      chk($sformatf("mulstream%0d_alt_stall", i), a_stall, (i % 5) != 0);
      next();
    end
    idle();
    #1;
    chk("mulstream_count", stall_count, 24);
    chk("alt_count_saturated", a_stall_count, 4'hF);
    next();
    chk("alt_count_held", a_stall_count, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
